// File: rtl/rr_arbiter8_enc_if.sv
// Request/grant bundle for the 8-way round-robin arbiter.
// The owner-done strobe is named rel because release is a reserved word.
interface rr_arbiter8_enc_if;
  logic       en;
  logic [7:0] req;
  logic       rel;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       gnt_timeout;

  modport master (
    output en,
    output req,
    output rel,
    input  gnt_idx,
    input  gnt_valid,
    input  gnt_timeout
  );

  modport slave (
    input  en,
    input  req,
    input  rel,
    output gnt_idx,
    output gnt_valid,
    output gnt_timeout
  );
endinterface

// File: rtl/rr_arbiter8_enc.sv
// 8-requester round-robin arbiter with a registered binary grant index,
// grant hold until release/request drop, and an optional hold-time limit.
module rr_arbiter8_enc #(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned CNT_W    = 5
) (
  input  logic               clk,
  input  logic               rst,
  rr_arbiter8_enc_if.slave   bus
);

  typedef enum logic {StIdle, StGrant} state_e;

  state_e           state_q, state_d;
  logic [2:0]       ptr_q, ptr_d;
  logic [2:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             to_q, to_d;

  logic [2:0]       win_idx;
  logic             win_found;
  logic             owner_end;
  logic             hold_hit;

  // Scan from the highest offset down so the lowest offset from ptr wins.
  always_comb begin
    win_idx   = ptr_q;
    win_found = |bus.req;
    for (int k = 7; k >= 0; k--) begin
      if (bus.req[ptr_q + 3'(k)]) begin
        win_idx = ptr_q + 3'(k);
      end
    end
  end

  assign owner_end = bus.rel | ~bus.req[idx_q];
  assign hold_hit  = (MAX_HOLD != 0) && (cnt_q == CNT_W'(MAX_HOLD - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    to_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.en && win_found) begin
          state_d = StGrant;
          idx_d   = win_idx;
          cnt_d   = '0;
        end
      end
      StGrant: begin
        if (owner_end || hold_hit) begin
          state_d = StIdle;
          ptr_d   = idx_q + 3'd1;
          cnt_d   = '0;
          // Timeout is flagged only when the hold limit alone ended the grant.
          to_d    = hold_hit & ~owner_end;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    bus.gnt_idx     = idx_q;
    bus.gnt_valid   = (state_q == StGrant);
    bus.gnt_timeout = to_q;
  end

endmodule

// File: tb/tb_rr_arbiter8_enc.sv
// Bench for rr_arbiter8_enc: directed table, corner sequences and random
// traffic on two instances (hold limits 16 and 4) against a grant model.
module tb_rr_arbiter8_enc;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] req;
  logic       rel;

  always #5 clk = ~clk;

  rr_arbiter8_enc_if if16();
  rr_arbiter8_enc_if if4();

  assign if16.en  = en;
  assign if16.req = req;
  assign if16.rel = rel;
  assign if4.en   = en;
  assign if4.req  = req;
  assign if4.rel  = rel;

  rr_arbiter8_enc #(.MAX_HOLD(16), .CNT_W(5)) dut16 (.clk(clk), .rst(rst), .bus(if16.slave));
  rr_arbiter8_enc #(.MAX_HOLD(4),  .CNT_W(3)) dut4  (.clk(clk), .rst(rst), .bus(if4.slave));

  int n_chk  = 0;
  int n_fail = 0;

  // Model state: who owns the grant, how many cycles it has been visible.
  int unsigned lim [2] = '{16, 4};
  bit          busy[2];
  int          own [2];
  int          mptr[2];
  int          held[2];
  bit          mto [2];

  typedef struct packed {
    logic       en;
    logic [7:0] req;
    logic       rel;
    logic       v;
    logic [2:0] idx;
    logic       to;
  } vec_t;

  vec_t tbl[16];

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      busy[d] = 0; own[d] = 0; mptr[d] = 0; held[d] = 0; mto[d] = 0;
    end
  endtask

  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      if (busy[d]) begin
        bit early = rel || !req[own[d]];
        if (early || (lim[d] != 0 && held[d] == int'(lim[d]))) begin
          busy[d] = 0;
          mptr[d] = (own[d] + 1) % 8;
          mto[d]  = !early;
        end else begin
          held[d]++;
          mto[d] = 0;
        end
      end else begin
        mto[d] = 0;
        if (en && req != 8'h00) begin
          for (int k = 7; k >= 0; k--) begin
            if (req[(mptr[d] + k) % 8]) own[d] = (mptr[d] + k) % 8;
          end
          busy[d] = 1;
          held[d] = 1;
        end
      end
    end
  endtask

  task automatic compare();
    check("valid16", int'(if16.gnt_valid), int'(busy[0]));
    check("idx16", int'(if16.gnt_idx), own[0]);
    check("timeout16", int'(if16.gnt_timeout), int'(mto[0]));
    check("valid4", int'(if4.gnt_valid), int'(busy[1]));
    check("idx4", int'(if4.gnt_idx), own[1]);
    check("timeout4", int'(if4.gnt_timeout), int'(mto[1]));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare();
  endtask

  // Reset is applied between edges to exercise its asynchronous path.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_reset();
    compare();
    #2;
    rst = 1'b0;
  endtask

  initial begin
    int cnt;
    int seq[$];
    rst = 1'b0; en = 1'b0; req = 8'h00; rel = 1'b0;
    #2;
    do_reset();

    // Enable gating, en drop mid-grant, release, owner drop, ptr rotation.
    for (int i = 0; i < 5; i++) tbl[i] = {1'b0, 8'h10, 1'b0, 1'b0, 3'd0, 1'b0};
    tbl[5]  = {1'b1, 8'h10, 1'b0, 1'b1, 3'd4, 1'b0};
    tbl[6]  = {1'b0, 8'h10, 1'b0, 1'b1, 3'd4, 1'b0};
    tbl[7]  = {1'b0, 8'h10, 1'b0, 1'b1, 3'd4, 1'b0};
    tbl[8]  = {1'b0, 8'h10, 1'b1, 1'b0, 3'd4, 1'b0};
    tbl[9]  = {1'b0, 8'h10, 1'b0, 1'b0, 3'd4, 1'b0};
    tbl[10] = {1'b1, 8'h11, 1'b0, 1'b1, 3'd0, 1'b0};
    tbl[11] = {1'b1, 8'h11, 1'b1, 1'b0, 3'd0, 1'b0};
    tbl[12] = {1'b1, 8'h11, 1'b0, 1'b1, 3'd4, 1'b0};
    tbl[13] = {1'b1, 8'h01, 1'b0, 1'b0, 3'd4, 1'b0};
    tbl[14] = {1'b1, 8'h01, 1'b0, 1'b1, 3'd0, 1'b0};
    tbl[15] = {1'b1, 8'h01, 1'b1, 1'b0, 3'd0, 1'b0};
    for (int i = 0; i < 16; i++) begin
      en = tbl[i].en; req = tbl[i].req; rel = tbl[i].rel;
      step();
      check($sformatf("tbl%0d_valid", i), int'(if16.gnt_valid), int'(tbl[i].v));
      check($sformatf("tbl%0d_idx", i), int'(if16.gnt_idx), int'(tbl[i].idx));
      check($sformatf("tbl%0d_to", i), int'(if16.gnt_timeout), int'(tbl[i].to));
    end

    // Reset mid-grant.
    en = 1'b0; rel = 1'b0; req = 8'h00;
    do_reset();
    en = 1'b1; req = 8'h08;
    step(); step(); step();
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_reset();
    check("rstmid_valid", int'(if16.gnt_valid), 0);
    check("rstmid_idx", int'(if16.gnt_idx), 0);
    check("rstmid_to", int'(if16.gnt_timeout), 0);
    #2;
    rst = 1'b0;
    step();
    check("rstmid_regrant_idx", int'(if16.gnt_idx), 3);
    check("rstmid_regrant_valid", int'(if16.gnt_valid), 1);

    // Wrap-around with release in every grant's first cycle.
    do_reset();
    en = 1'b1; req = 8'hFF; rel = 1'b1;
    for (int i = 0; i < 18; i++) begin
      step();
      check($sformatf("wrap_valid%0d", i), int'(if16.gnt_valid), (i % 2 == 0) ? 1 : 0);
      if (if16.gnt_valid) seq.push_back(int'(if16.gnt_idx));
    end
    check("wrap_count", seq.size(), 9);
    for (int i = 0; i < seq.size(); i++) check($sformatf("wrap_idx%0d", i), seq[i], i % 8);

    // Sparse fairness: two-cycle grants alternating 0 and 7.
    rel = 1'b0;
    do_reset();
    req = 8'h81;
    for (int g = 0; g < 4; g++) begin
      rel = 1'b0;
      step();
      check($sformatf("sparse%0d_idx", g), int'(if16.gnt_idx), (g % 2 == 0) ? 0 : 7);
      check($sformatf("sparse%0d_v1", g), int'(if16.gnt_valid), 1);
      step();
      check($sformatf("sparse%0d_v2", g), int'(if16.gnt_valid), 1);
      rel = 1'b1;
      step();
      check($sformatf("sparse%0d_end", g), int'(if16.gnt_valid), 0);
    end

    // Timeout of a lone requester on the 16-cycle instance.
    rel = 1'b0;
    do_reset();
    req = 8'h08;
    step();
    cnt = if16.gnt_valid ? 1 : 0;
    while (if16.gnt_valid && cnt < 40) begin
      step();
      if (if16.gnt_valid) cnt++;
    end
    check("timeout_width", cnt, 16);
    check("timeout_pulse", int'(if16.gnt_timeout), 1);
    step();
    check("timeout_regrant_valid", int'(if16.gnt_valid), 1);
    check("timeout_regrant_idx", int'(if16.gnt_idx), 3);
    check("timeout_pulse_gone", int'(if16.gnt_timeout), 0);

    // Release and request drop coinciding with the 4-cycle limit.
    for (int r = 0; r < 2; r++) begin
      rel = 1'b0; req = 8'h08;
      do_reset();
      step(); step(); step(); step();
      check($sformatf("simul%0d_held", r), int'(if4.gnt_valid), 1);
      if (r == 0) rel = 1'b1;
      else req = 8'h00;
      step();
      check($sformatf("simul%0d_valid", r), int'(if4.gnt_valid), 0);
      check($sformatf("simul%0d_to", r), int'(if4.gnt_timeout), 0);
    end

    // Random traffic; requests are sticky so the hold limits get exercised.
    rel = 1'b0; req = 8'h00;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      en  = ($urandom_range(0, 3) != 0);
      rel = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 3) == 0) req = 8'($urandom);
      if ($urandom_range(0, 399) == 0) do_reset();
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_arbiter8_enc.md
Name: rr_arbiter8_enc

Overview:
- 8-requester round-robin arbiter; outputs the winning requester as a registered 3-bit binary index plus a valid flag.
- Sits directly upstream of the 3-to-8 one-hot decoder: gnt_idx drives the decoder select, and the consumer gates the decoder outputs with gnt_valid.
- Grant is held until the owner releases it, drops its request, or exceeds a hold limit.

Parameters:
- MAX_HOLD, 16, maximum cycles gnt_valid may stay high for one grant; 0 = no limit.
- CNT_W, 5, hold-counter width; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- en  input  1  arbitration enable; gates new grants only
- req  input  8  request vector, bit k = requester k
- release  input  1  owner done; ends current grant at this edge
- gnt_idx  output  3  index of granted requester (registered)
- gnt_valid  output  1  gnt_idx is a live grant
- gnt_timeout  output  1  1-cycle pulse: grant ended by MAX_HOLD

Behaviour:
- Reset (async, immediate, also mid-grant):
  - gnt_idx=0, gnt_valid=0, gnt_timeout=0.
  - Priority pointer ptr=0, hold counter=0, state IDLE.
- States: IDLE, GRANT. gnt_valid is 1 exactly when state==GRANT.
- IDLE, at each edge:
  - If en=1 and req!=0: winner = first set bit of req searching ptr, ptr+1, ..., wrapping 7->0.
  - Register gnt_idx<=winner, gnt_valid<=1, counter<=0, state<=GRANT.
  - Latency: grant visible 1 cycle after the edge that sampled req.
- IDLE, en=0 or req=0: no change; gnt_idx keeps its last value.
- GRANT, at each edge, evaluate end conditions on current inputs:
  - (a) release=1
  - (b) req[gnt_idx]=0
  - (c) MAX_HOLD!=0 and counter==MAX_HOLD-1
- Any end condition true:
  - gnt_valid<=0, state<=IDLE.
  - ptr<=(gnt_idx+1) mod 8; 7 wraps to 0.
  - counter<=0.
  - gnt_idx holds its value.
- No end condition: counter<=counter+1; gnt_idx, gnt_valid and ptr unchanged.
- gnt_timeout:
  - Pulses 1 cycle, coincident with the cycle gnt_valid first reads 0.
  - Asserted only if (c) is the sole end condition; (a) or (b) on the same edge suppress it.
- Hold bound: with MAX_HOLD=N>0, gnt_valid is high for at most N consecutive cycles.
- Inter-grant gap: at least one cycle with gnt_valid=0 between consecutive grants. A new grant may be issued on the first IDLE edge.
- Timeout requester: the timed-out requester is not blocked; it is re-eligible under round-robin order from the updated ptr.
- en deassertion during GRANT: does not abort the grant; it only blocks the next one.
- req changes of non-owners during GRANT: ignored until IDLE.
- ptr behaviour: ptr updates only at grant end, never in IDLE. The first grant after reset favours requester 0.

Test Plan:
- Reset mid-grant:
  - Stimulus: req=8'h08, en=1, wait 3 cycles into the grant, pulse rst asynchronously between edges.
  - Response: gnt_valid, gnt_idx and gnt_timeout go to 0 immediately. The first grant after rst release is idx 3.
- Wrap-around:
  - Stimulus: req=8'hFF held, en=1, release=1 during each grant's first cycle.
  - Response: gnt_idx sequence 0,1,2,3,4,5,6,7,0. gnt_valid high 1 cycle per grant, 1 idle cycle between grants.
- Sparse fairness:
  - Stimulus: req=8'b1000_0001, release after 2 grant cycles.
  - Response: gnt_idx alternates 0,7,0,7; each grant is 2 cycles wide.
- Timeout:
  - Stimulus: MAX_HOLD=16, req=8'h08 held, release=0.
  - Response: gnt_valid high exactly 16 cycles, then gnt_timeout=1 for 1 cycle with gnt_valid=0. Next grant is idx 3, one idle cycle later.
- Simultaneous end conditions:
  - Stimulus: MAX_HOLD=4, release=1 on the 4th grant cycle.
  - Response: grant ends at that edge and gnt_timeout stays 0.
  - Repeat with req[owner] dropped on the 4th grant cycle instead of release: same result, gnt_timeout=0.
- Enable gating:
  - Stimulus: en=0, req=8'h10 for 5 cycles, then en=1.
  - Response: gnt_valid stays 0 while en=0, then gnt_idx=4 and gnt_valid=1 one cycle after the edge where en=1 is sampled.
  - Dropping en mid-grant does not end that grant.
